// File: rtl/clk_duty_monitor.sv
`timescale 1ns/1ps
// Divided-clock checker: measures the period and high time of mon_clk in clk cycles,
// flags values outside tolerance, tracks lock and raises a timeout on a missing edge.
module clk_duty_monitor #(
    parameter int CNT_W      = 8,
    parameter int EXP_PERIOD = 10,
    parameter int EXP_HIGH   = 4,
    parameter int TOL        = 0,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_err,
    input  logic             mon_clk,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_cnt,
    output logic [CNT_W-1:0] high_cnt,
    output logic             period_err,
    output logic             duty_err,
    output logic             err_sticky,
    output logic             timeout,
    output logic             locked
);
    localparam int GR_W = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] EXP_P_C = EXP_PERIOD[CNT_W-1:0];
    localparam logic [CNT_W-1:0] EXP_H_C = EXP_HIGH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] TOL_C   = TOL[CNT_W-1:0];
    localparam logic [CNT_W-1:0] TO_C    = TIMEOUT[CNT_W-1:0];
    localparam logic [GR_W-1:0]  LOCK_C  = LOCK_CNT[GR_W-1:0];

    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW} state_t;

    state_t           state_q, state_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] h_tmp_q, h_tmp_d;
    logic [GR_W-1:0]  good_run_q, good_run_d;
    logic             meas_valid_q, meas_valid_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic             period_err_q, period_err_d;
    logic             duty_err_q, duty_err_d;
    logic             err_sticky_q, err_sticky_d;
    logic             timeout_q, timeout_d;
    logic             locked_q, locked_d;

    logic rise, fall, measure, to_hit, perr_new, derr_new;

    function automatic logic out_of_tol(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] e);
        logic [CNT_W-1:0] diff;
        diff = (v >= e) ? v - e : e - v;
        return diff > TOL_C;
    endfunction

    always_comb begin
        rise     = mon_clk & ~prev_q;
        fall     = ~mon_clk & prev_q;
        measure  = (state_q == S_LOW) && rise;
        // Awaited edge wins over a timeout landing on the same cycle.
        to_hit   = (state_q != S_IDLE) && (cnt_q >= TO_C) &&
                   !((state_q == S_HIGH) ? fall : rise);
        perr_new = out_of_tol(cnt_q, EXP_P_C);
        derr_new = out_of_tol(h_tmp_q, EXP_H_C);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (rise) state_d = S_HIGH;
            S_HIGH: if (fall) state_d = S_LOW;  else if (to_hit) state_d = S_IDLE;
            S_LOW:  if (rise) state_d = S_HIGH; else if (to_hit) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        prev_d       = mon_clk;
        cnt_d        = rise ? CNT_W'(1) : ((cnt_q == '1) ? cnt_q : cnt_q + 1'b1);
        h_tmp_d      = (state_q == S_HIGH && fall) ? cnt_q : h_tmp_q;
        meas_valid_d = measure;
        timeout_d    = to_hit;
        period_cnt_d = measure ? cnt_q   : period_cnt_q;
        high_cnt_d   = measure ? h_tmp_q : high_cnt_q;
        period_err_d = measure ? perr_new : period_err_q;
        duty_err_d   = measure ? derr_new : duty_err_q;
        good_run_d   = good_run_q;
        if (to_hit)
            good_run_d = '0;
        else if (measure)
            good_run_d = (perr_new || derr_new) ? '0 :
                         (good_run_q == LOCK_C) ? good_run_q : good_run_q + 1'b1;
        locked_d     = (good_run_d == LOCK_C);
        if ((measure && (perr_new || derr_new)) || to_hit) err_sticky_d = 1'b1;
        else if (clr_err)                                   err_sticky_d = 1'b0;
        else                                                err_sticky_d = err_sticky_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q       <= 1'b0;
            cnt_q        <= '0;
            h_tmp_q      <= '0;
            good_run_q   <= '0;
            meas_valid_q <= 1'b0;
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
            period_err_q <= 1'b0;
            duty_err_q   <= 1'b0;
            err_sticky_q <= 1'b0;
            timeout_q    <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            prev_q       <= prev_d;
            cnt_q        <= cnt_d;
            h_tmp_q      <= h_tmp_d;
            good_run_q   <= good_run_d;
            meas_valid_q <= meas_valid_d;
            period_cnt_q <= period_cnt_d;
            high_cnt_q   <= high_cnt_d;
            period_err_q <= period_err_d;
            duty_err_q   <= duty_err_d;
            err_sticky_q <= err_sticky_d;
            timeout_q    <= timeout_d;
            locked_q     <= locked_d;
        end
    end

    assign meas_valid = meas_valid_q;
    assign period_cnt = period_cnt_q;
    assign high_cnt   = high_cnt_q;
    assign period_err = period_err_q;
    assign duty_err   = duty_err_q;
    assign err_sticky = err_sticky_q;
    assign timeout    = timeout_q;
    assign locked     = locked_q;
endmodule

// File: tb/tb_clk_duty_monitor.sv
`timescale 1ns/1ps
// Bench for clk_duty_monitor: two instances (TOL=0 and TOL=1) share stimulus built as
// whole mon_clk pulses; expectations come from a pulse-level model of the measurement rules.
module tb_clk_duty_monitor;
    localparam int CW = 8, EXP_P = 10, EXP_H = 4, LOCK = 4, TO = 20;

    logic clk = 1'b0, rst, clr_err, mon_clk;
    logic          mv[2], pe[2], de[2], es[2], tmo[2], lk[2];
    logic [CW-1:0] pc[2], hc[2];

    clk_duty_monitor #(.CNT_W(CW), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(0),
                       .LOCK_CNT(LOCK), .TIMEOUT(TO)) dut0 (
        .clk(clk), .rst(rst), .clr_err(clr_err), .mon_clk(mon_clk),
        .meas_valid(mv[0]), .period_cnt(pc[0]), .high_cnt(hc[0]), .period_err(pe[0]),
        .duty_err(de[0]), .err_sticky(es[0]), .timeout(tmo[0]), .locked(lk[0]));

    clk_duty_monitor #(.CNT_W(CW), .EXP_PERIOD(EXP_P), .EXP_HIGH(EXP_H), .TOL(1),
                       .LOCK_CNT(LOCK), .TIMEOUT(TO)) dut1 (
        .clk(clk), .rst(rst), .clr_err(clr_err), .mon_clk(mon_clk),
        .meas_valid(mv[1]), .period_cnt(pc[1]), .high_cnt(hc[1]), .period_err(pe[1]),
        .duty_err(de[1]), .err_sticky(es[1]), .timeout(tmo[1]), .locked(lk[1]));

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // Pulse-level model: previous pulse shape, whether it is measurable, and per-instance state.
    bit armed;
    int prev_h, prev_l;
    int gr[2], m_pc[2], m_hc[2];
    bit m_pe[2], m_de[2], m_es[2], m_lk[2];

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic model_reset();
        armed = 0; prev_h = 0; prev_l = 0;
        for (int k = 0; k < 2; k++) begin
            gr[k] = 0; m_pc[k] = 0; m_hc[k] = 0;
            m_pe[k] = 0; m_de[k] = 0; m_es[k] = 0; m_lk[k] = 0;
        end
    endtask

    // One pulse: h samples high then l samples low, clr_err raised on sample clr_idx.
    // Every sample is compared on both instances.
    task automatic drive_pulse(input int h, input int l, input int clr_idx);
        bit to_fire;
        to_fire = (TO < h + l);
        for (int i = 0; i < h + l; i++) begin
            bit mv_e, to_e;
            bit set_e[2];
            mon_clk = (i < h);
            clr_err = (i == clr_idx);
            step();
            mv_e = (i == 0) && armed;
            to_e = to_fire && (i == TO);
            for (int k = 0; k < 2; k++) begin
                set_e[k] = 0;
                if (mv_e) begin
                    m_pc[k] = prev_h + prev_l;
                    m_hc[k] = prev_h;
                    m_pe[k] = iabs(m_pc[k] - EXP_P) > k;
                    m_de[k] = iabs(m_hc[k] - EXP_H) > k;
                    if (m_pe[k] || m_de[k]) begin gr[k] = 0; set_e[k] = 1; end
                    else if (gr[k] < LOCK) gr[k]++;
                    m_lk[k] = (gr[k] == LOCK);
                end
                if (to_e) begin gr[k] = 0; m_lk[k] = 0; set_e[k] = 1; end
                m_es[k] = set_e[k] ? 1'b1 : (clr_err ? 1'b0 : m_es[k]);

                checks += 8;
                if (mv[k] !== mv_e) begin failures++;
                    $display("FAIL meas_valid[%0d] @%0t got=%b exp=%b", k, $time, mv[k], mv_e); end
                if (tmo[k] !== to_e) begin failures++;
                    $display("FAIL timeout[%0d] @%0t got=%b exp=%b", k, $time, tmo[k], to_e); end
                if (pc[k] !== CW'(m_pc[k])) begin failures++;
                    $display("FAIL period_cnt[%0d] @%0t got=%0d exp=%0d", k, $time, pc[k], m_pc[k]); end
                if (hc[k] !== CW'(m_hc[k])) begin failures++;
                    $display("FAIL high_cnt[%0d] @%0t got=%0d exp=%0d", k, $time, hc[k], m_hc[k]); end
                if (pe[k] !== m_pe[k]) begin failures++;
                    $display("FAIL period_err[%0d] @%0t got=%b exp=%b", k, $time, pe[k], m_pe[k]); end
                if (de[k] !== m_de[k]) begin failures++;
                    $display("FAIL duty_err[%0d] @%0t got=%b exp=%b", k, $time, de[k], m_de[k]); end
                if (es[k] !== m_es[k]) begin failures++;
                    $display("FAIL err_sticky[%0d] @%0t got=%b exp=%b", k, $time, es[k], m_es[k]); end
                if (lk[k] !== m_lk[k]) begin failures++;
                    $display("FAIL locked[%0d] @%0t got=%b exp=%b", k, $time, lk[k], m_lk[k]); end
            end
        end
        clr_err = 0;
        armed   = !to_fire;
        prev_h  = h;
        prev_l  = l;
    endtask

    task automatic test_reset();
        rst = 1; clr_err = 0; mon_clk = 0;
        model_reset();
        repeat (3) step();
        rst = 0;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if ({mv[k], pe[k], de[k], es[k], tmo[k], lk[k], pc[k], hc[k]} !== '0) begin
                    failures++;
                    $display("FAIL reset_outputs[%0d] @%0t got=%b exp=0", k, $time,
                             {mv[k], pe[k], de[k], es[k], tmo[k], lk[k], pc[k], hc[k]});
                end
            end
            step();
        end
    endtask

    task automatic test_nominal();
        repeat (6) drive_pulse(4, 6, -1);
    endtask

    task automatic test_stretch();
        drive_pulse(4, 7, -1);
        repeat (5) drive_pulse(4, 6, -1);
        drive_pulse(4, 6, 3);
    endtask

    task automatic test_duty();
        repeat (6) drive_pulse(5, 5, -1);
        drive_pulse(4, 6, 2);
    endtask

    task automatic test_timeout();
        repeat (5) drive_pulse(4, 6, -1);
        drive_pulse(30, 6, -1);
        repeat (6) drive_pulse(4, 6, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int h, l, c;
            case ($urandom_range(0, 3))
                0: begin h = 4; l = 6; end
                1: begin h = 5; l = 5; end
                2: begin h = 4; l = 7; end
                default: begin h = $urandom_range(1, 9); l = $urandom_range(1, 9); end
            endcase
            c = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, h + l - 1)) : -1;
            drive_pulse(h, l, c);
        end
    endtask

    task automatic test_reset_mid();
        repeat (6) drive_pulse(4, 6, -1);
        drive_pulse(4, 7, -1);
        drive_pulse(4, 6, -1);
        mon_clk = 1;
        step(); step();
        rst = 1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({mv[k], pe[k], de[k], es[k], tmo[k], lk[k], pc[k], hc[k]} !== '0) begin
                failures++;
                $display("FAIL rst_mid_outputs[%0d] @%0t got=%b exp=0", k, $time,
                         {mv[k], pe[k], de[k], es[k], tmo[k], lk[k], pc[k], hc[k]});
            end
        end
        step();
        rst = 0;
        drive_pulse(4, 6, -1);
        drive_pulse(4, 7, -1);
        drive_pulse(4, 6, 0);
        repeat (2) drive_pulse(4, 6, -1);
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stretch();
        test_duty();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
